// File: rtl/draw_falling_bar.sv
// Falling obstacle bar overlaid on the background pixel stream, with collision and completion pulses.
// Optional macro BAR_GAP_EN adds an LFSR-placed 60-column gap that is neither drawn nor collidable.
module draw_falling_bar #(
    parameter int          TOP_V_LINE    = 317,
    parameter int          BOTTOM_V_LINE = 617,
    parameter int          LEFT_H_LINE   = 361,
    parameter int          RIGHT_H_LINE  = 661,
    parameter int          BAR_HEIGHT    = 20,
    parameter int          SPEED         = 2,
    parameter int          WARN_FRAMES   = 60,
    parameter logic [11:0] BAR_COLOR     = 12'hf_0_0,
    parameter logic [11:0] WARN_COLOR    = 12'hf_8_0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic [11:0] vcount_in,
    input  logic [11:0] hcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] rgb_in,
    input  logic        enable,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [11:0] vcount_out,
    output logic [11:0] hcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] rgb_out,
    output logic        hit,
    output logic        done
);
    localparam int          CNT_W     = 6;
    localparam logic [11:0] TOP       = 12'(TOP_V_LINE);
    localparam logic [11:0] LEFT      = 12'(LEFT_H_LINE);
    localparam logic [11:0] RIGHT     = 12'(RIGHT_H_LINE);
    localparam logic [11:0] HEIGHT    = 12'(BAR_HEIGHT);
    localparam logic [11:0] BAR_LIMIT = 12'(BOTTOM_V_LINE - BAR_HEIGHT);

    typedef enum logic [1:0] {IDLE, WARN, FALL, DONE} state_t;

    state_t             state, state_nxt;
    logic [11:0]        bar_y, bar_y_nxt, bar_step;
    logic [CNT_W-1:0]   frame_cnt, frame_cnt_nxt;
    logic               vblnk_q, tick;
    logic               pix_cols, pix_bar_rows, pix_warn_rows, player_in_bar;
    logic               pix_gap, player_gap;
    logic [11:0]        rgb_nxt;
    logic               hit_nxt;

    assign tick          = vblnk_in & ~vblnk_q;
    assign pix_cols      = (hcount_in >= LEFT) && (hcount_in < RIGHT);
    assign pix_bar_rows  = (vcount_in >= bar_y) && (vcount_in < bar_y + HEIGHT);
    assign pix_warn_rows = (vcount_in >= TOP) && (vcount_in <= TOP + 12'd3);
    assign player_in_bar = (xpos >= LEFT) && (xpos < RIGHT) &&
                           (ypos >= bar_y) && (ypos < bar_y + HEIGHT) && !player_gap;
    assign bar_step      = bar_y + 12'(SPEED);

`ifdef BAR_GAP_EN
    logic [7:0]  lfsr, lfsr_mod;
    logic [11:0] gap_x;

    assign lfsr_mod   = (lfsr >= 8'd200) ? lfsr - 8'd200 : lfsr;
    assign pix_gap    = (hcount_in >= gap_x) && (hcount_in < gap_x + 12'd60);
    assign player_gap = (xpos >= gap_x) && (xpos < gap_x + 12'd60);

    // gap position latches the LFSR value seen at the tick that enters FALL
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            lfsr  <= 8'h5A;
            gap_x <= '0;
        end else begin
            if (tick)
                lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            if (state != FALL && state_nxt == FALL)
                gap_x <= LEFT + 12'd20 + {4'd0, lfsr_mod};
        end
    end
`else
    assign pix_gap    = 1'b0;
    assign player_gap = 1'b0;
`endif

    always_comb begin
        state_nxt     = state;
        bar_y_nxt     = bar_y;
        frame_cnt_nxt = frame_cnt;
        hit_nxt       = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            bar_y_nxt = TOP;
        end else begin
            case (state)
                IDLE: if (tick) begin
                    state_nxt     = WARN;
                    frame_cnt_nxt = '0;
                end
                WARN: if (tick) begin
                    if (frame_cnt == CNT_W'(WARN_FRAMES - 1)) begin
                        state_nxt = FALL;
                        bar_y_nxt = TOP;
                    end else begin
                        frame_cnt_nxt = frame_cnt + CNT_W'(1);
                    end
                end
                FALL: if (tick) begin
                    hit_nxt = player_in_bar;
                    if (bar_y >= BAR_LIMIT)
                        state_nxt = DONE;
                    else
                        bar_y_nxt = (bar_step > BAR_LIMIT) ? BAR_LIMIT : bar_step;
                end
                DONE: state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        rgb_nxt = rgb_in;
        if (enable && !vblnk_in && !hblnk_in && pix_cols) begin
            if (state == WARN && frame_cnt[3] && pix_warn_rows)
                rgb_nxt = WARN_COLOR;
            else if (state == FALL && pix_bar_rows && !pix_gap)
                rgb_nxt = BAR_COLOR;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bar_y      <= TOP;
            frame_cnt  <= '0;
            vblnk_q    <= 1'b0;
            vcount_out <= '0;
            hcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            rgb_out    <= '0;
            hit        <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            bar_y      <= bar_y_nxt;
            frame_cnt  <= frame_cnt_nxt;
            vblnk_q    <= vblnk_in;
            vcount_out <= vcount_in;
            hcount_out <= hcount_in;
            vsync_out  <= vsync_in;
            vblnk_out  <= vblnk_in;
            hsync_out  <= hsync_in;
            hblnk_out  <= hblnk_in;
            rgb_out    <= rgb_nxt;
            hit        <= hit_nxt;
            done       <= (state_nxt == DONE);
        end
    end
endmodule

// File: tb/tb_draw_falling_bar.sv
// Bench for draw_falling_bar: compressed frames of probe pixels checked against a tick-count model.
module tb_draw_falling_bar;
    localparam int TOP = 317, LEFT = 361, RIGHT = 661;

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] vcount_in = '0, hcount_in = '0, rgb_in = '0, xpos = '0, ypos = '0;
    logic        vsync_in = 1'b0, vblnk_in = 1'b0, hsync_in = 1'b0, hblnk_in = 1'b0, enable = 1'b0;
    logic [11:0] vcount_out, hcount_out, rgb_out;
    logic        vsync_out, vblnk_out, hsync_out, hblnk_out, hit, done;

    draw_falling_bar dut (
        .pclk(pclk), .rst(rst),
        .vcount_in(vcount_in), .hcount_in(hcount_in),
        .vsync_in(vsync_in), .vblnk_in(vblnk_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
        .rgb_in(rgb_in), .enable(enable), .xpos(xpos), .ypos(ypos),
        .vcount_out(vcount_out), .hcount_out(hcount_out),
        .vsync_out(vsync_out), .vblnk_out(vblnk_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .rgb_out(rgb_out), .hit(hit), .done(done)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic [11:0] v, h, rgb;
        logic [3:0]  sync;
        logic        hit, done;
    } exp_t;

    exp_t q[$];
    exp_t ce;
    int   compared = 0, mismatched = 0;
    int   done_seen = 0, hit_seen = 0;
    // model: -1 idle, 0..59 warn frames, 60..200 falling, -2 the single done cycle
    int   t_m = -1;
    bit   prev_vb = 1'b0;

    function automatic int bar_of(int t);
        int b;
        b = TOP + 2 * (t - 60);
        return (b > 597) ? 597 : b;
    endfunction

    function automatic logic [11:0] model_rgb(int t, bit en, int v, int h, bit vb, bit hb,
                                              logic [11:0] rin);
        if (vb || hb || !en || h < LEFT || h >= RIGHT) return rin;
        if (t >= 0 && t <= 59) begin
            if (((t / 8) % 2) == 1 && v >= TOP && v <= TOP + 3) return 12'hf80;
        end else if (t >= 60 && t <= 200) begin
            if (v >= bar_of(t) && v < bar_of(t) + 20) return 12'hf00;
        end
        return rin;
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", name, act, expv, t_m, $time);
        end
    endtask

    task automatic drive(input int v, input int h, input bit vb, input bit hb);
        exp_t        e;
        bit          tk;
        logic [11:0] r;
        int          xp, yp;
        r = 12'($urandom_range(4095));
        vcount_in = 12'(v); hcount_in = 12'(h); vblnk_in = vb; hblnk_in = hb; rgb_in = r;
        vsync_in = 1'($urandom_range(1)); hsync_in = 1'($urandom_range(1));
        tk = vb && !prev_vb;
        xp = int'(xpos); yp = int'(ypos);
        e.v = 12'(v); e.h = 12'(h); e.sync = {vsync_in, vb, hsync_in, hb};
        e.rgb  = model_rgb(t_m, enable, v, h, vb, hb, r);
        e.hit  = enable && tk && t_m >= 60 && t_m <= 200 && xp >= LEFT && xp < RIGHT &&
                 yp >= bar_of(t_m) && yp < bar_of(t_m) + 20;
        e.done = enable && tk && t_m == 200;
        @(posedge pclk);
        q.push_back(e);
        if (!enable) t_m = -1;
        else if (t_m == -2) t_m = -1;
        else if (tk) t_m = (t_m == 200) ? -2 : t_m + 1;
        prev_vb = vb;
        #1;
    endtask

    task automatic frame(input int k);
        int rows[10];
        int cols[5];
        int b;
        b = (t_m >= 60 && t_m <= 200) ? bar_of(t_m) : 401;
        rows = '{316, 317, 320, 321, b - 1, b, b + 19, b + 20, 616, 617};
        cols = '{360, 361, 500, 660, 661};
        foreach (rows[i]) drive(rows[i], cols[(i + k) % 5], 1'b0, 1'b0);
        drive(b, 500, 1'b0, 1'b1);
        drive(0, 0, 1'b1, 1'b0);
        drive(0, 0, 1'b1, 1'b0);
        drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic set_player(input int k);
        int xs[5];
        int offs[5];
        xs = '{500, 361, 660, 661, 360};
        offs = '{-1, 0, 19, 20, 10};
        if (t_m >= 60 && t_m <= 200) begin
            xpos = 12'(xs[k % 5]);
            ypos = 12'(bar_of(t_m) + offs[(k / 5) % 5]);
        end else begin
            xpos = 12'($urandom_range(1023));
            ypos = 12'($urandom_range(1023));
        end
    endtask

    always @(negedge pclk) begin
        if (q.size() > 0) begin
            ce = q.pop_front();
            check("rgb_out", rgb_out, ce.rgb);
            check("vcount_out", vcount_out, ce.v);
            check("hcount_out", hcount_out, ce.h);
            check("sync_blank", {8'd0, vsync_out, vblnk_out, hsync_out, hblnk_out}, {8'd0, ce.sync});
            check("hit", {11'd0, hit}, {11'd0, ce.hit});
            check("done", {11'd0, done}, {11'd0, ce.done});
            if (done) done_seen++;
            if (hit) hit_seen++;
        end
    end

    task automatic check_all_zero(input string name);
        check({name, "_rgb"}, rgb_out, 12'h000);
        check({name, "_cnt"}, vcount_out | hcount_out, 12'h000);
        check({name, "_flags"}, {6'd0, vsync_out, vblnk_out, hsync_out, hblnk_out, hit, done}, 12'h000);
    endtask

    initial begin
        int nfr, hb0;
        #2 rst = 1'b1;
        #2 check_all_zero("reset_init");
        @(negedge pclk) rst = 1'b0;

        for (int k = 0; k < 2; k++) begin set_player(k); frame(k); end

        // run 1: full warn, fall and completion
        enable = 1'b1;
        nfr = 0;
        for (int k = 0; k < 260; k++) begin
            if (t_m == 7)  begin drive(317, 400, 0, 0); check("lit_warn_off", rgb_out, rgb_in); end
            if (t_m == 8)  begin drive(317, 400, 0, 0); check("lit_warn_on", rgb_out, 12'hf80);
                                 drive(321, 400, 0, 0); check("lit_warn_row", rgb_out, rgb_in); end
            if (t_m == 60) begin
                drive(317, 361, 0, 0); check("lit_bar_first_tl", rgb_out, 12'hf00);
                drive(336, 660, 0, 0); check("lit_bar_first_br", rgb_out, 12'hf00);
                drive(337, 500, 0, 0); check("lit_bar_first_below", rgb_out, rgb_in);
                xpos = 12'd500; ypos = 12'd330;
                hb0 = hit_seen;
                frame(k);
                check("lit_hit_first_fall", 12'(hit_seen - hb0), 12'd1);
            end else begin
                if (t_m == 200) begin
                    drive(616, 400, 0, 0); check("lit_bar_last_row", rgb_out, 12'hf00);
                    drive(617, 400, 0, 0); check("lit_border_617", rgb_out, rgb_in);
                end
                set_player(k);
                frame(k);
            end
            nfr++;
            if (t_m == -1) break;
        end
        check("lit_run1_frames", 12'(nfr), 12'd202);
        check("lit_run1_done_count", 12'(done_seen), 12'd1);
        frame(0);

        // run 2: near-miss collisions, then enable dropped mid-fall
        enable = 1'b1;
        for (int k = 0; k < 200 && t_m != 127; k++) begin
            if (t_m == 60) begin xpos = 12'd500; ypos = 12'd337; end
            else if (t_m == 61) begin xpos = 12'd661; ypos = 12'd330; end
            else set_player(k);
            hb0 = hit_seen;
            frame(k);
            if (t_m == 61 || t_m == 62) check("lit_no_hit_edge", 12'(hit_seen - hb0), 12'd0);
        end
        drive(451, 500, 0, 0); check("lit_bar_451", rgb_out, 12'hf00);
        enable = 1'b0;
        drive(451, 500, 0, 0); check("lit_disabled_451", rgb_out, rgb_in);
        frame(1); frame(2);
        drive(451, 500, 0, 0); check("lit_disabled_next_frame", rgb_out, rgb_in);
        check("lit_run2_done_count", 12'(done_seen), 12'd1);

        // run 3: asynchronous reset while the bar sits at row 401
        enable = 1'b1;
        for (int k = 0; k < 200 && t_m != 102; k++) begin set_player(k); frame(k); end
        drive(401, 500, 0, 0); check("lit_bar_401", rgb_out, 12'hf00);
        @(negedge pclk); #1;
        rst = 1'b1;
        #1 check_all_zero("reset_midfall");
        vcount_in = 12'd401; hcount_in = 12'd500; rgb_in = 12'h123; vsync_in = 1'b1; hsync_in = 1'b1;
        @(posedge pclk); #1 check_all_zero("reset_held");
        @(negedge pclk);
        vsync_in = 1'b0; hsync_in = 1'b0;
        rst = 1'b0;
        t_m = -1; prev_vb = 1'b0;
        drive(401, 500, 0, 0); check("lit_after_reset_pass", rgb_out, rgb_in);
        drive(402, 600, 0, 0); check("lit_after_reset_pass2", rgb_out, rgb_in);
        frame(3); frame(4);
        check("lit_reset_no_done", 12'(done_seen), 12'd1);

        @(negedge pclk); @(negedge pclk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
